// File: rtl/wb_result_unit.sv
// Writeback result unit: takes one retiring instruction, selects the ALU
// result or (after a bounded wait) extracted/extended load data, and drives
// the register-file write port.
module wb_result_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               mem_to_reg,
    input  logic               reg_write,
    input  logic [RADDR_W-1:0] rd,
    input  logic [1:0]         ld_size,
    input  logic               ld_unsigned,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_rvalid,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               busy,
    output logic               err_timeout
);

    // Counter only ever reaches TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               reg_write_q, reg_write_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [1:0]         off_q, off_d;
    logic               rf_we_q, rf_we_d;
    logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

    logic              accept;
    logic              timeout_hit;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] load_data;

    assign accept      = in_valid && (state_q != WAIT_MEM);
    assign timeout_hit = (state_q == WAIT_MEM) && !mem_rvalid && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and captured-field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    // Little-endian byte/half extraction with sign or zero extension
    always_comb begin
        byte_v = mem_rdata[{off_q, 3'b000} +: 8];
        half_v = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_data = uns_q ? {{(DATA_W-8){1'b0}}, byte_v}
                                       : {{(DATA_W-8){byte_v[7]}}, byte_v};
            2'b01:   load_data = uns_q ? {{(DATA_W-16){1'b0}}, half_v}
                                       : {{(DATA_W-16){half_v[15]}}, half_v};
            default: load_data = mem_rdata;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WRITE: begin
                if (accept) begin
                    state_d = mem_to_reg ? WAIT_MEM : WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d = WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture on accept; the write port register is loaded only when a real
    // write will occur, so rf_waddr/rf_wdata hold the last written values and
    // rf_we_q can only be high in WRITE.
    always_comb begin
        cnt_d       = cnt_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        if (accept) begin
            cnt_d       = '0;
            reg_write_d = reg_write;
            rd_d        = rd;
            size_d      = ld_size;
            uns_d       = ld_unsigned;
            off_d       = alu_result[1:0];
            if (!mem_to_reg && reg_write && (rd != '0)) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = rd;
                rf_wdata_d = alu_result;
            end
        end else if (state_q == WAIT_MEM) begin
            if (mem_rvalid) begin
                if (reg_write_q && (rd_q != '0)) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = rd_q;
                    rf_wdata_d = load_data;
                end
            end else if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        in_ready    = (state_q != WAIT_MEM);
        busy        = (state_q == WAIT_MEM);
        err_timeout = timeout_hit;
        rf_we       = rf_we_q;
        rf_waddr    = rf_waddr_q;
        rf_wdata    = rf_wdata_q;
    end

endmodule

// File: tb/tb_wb_result_unit.sv
// Directed bench for wb_result_unit with TIMEOUT=8.
module tb_wb_result_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    wb_result_unit #(
        .DATA_W  (32),
        .RADDR_W (5),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_result  (alu_result),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .rd          (rd),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [4:0] rd_i, input logic [31:0] val);
        in_valid    = 1'b1;
        alu_result  = val;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b1;
        rd          = rd_i;
        ld_size     = 2'b10;
        ld_unsigned = 1'b0;
    endtask

    // Accepts a load, delivers rdata on wait cycle nwait, checks busy on every
    // wait cycle, and returns at the negedge of the WRITE cycle.
    task automatic do_load(input string tag, input logic [4:0] rd_i, input logic [31:0] addr,
                           input logic [1:0] sz, input logic uns, input logic [31:0] rdata,
                           input int unsigned nwait);
        in_valid    = 1'b1;
        alu_result  = addr;
        mem_to_reg  = 1'b1;
        reg_write   = 1'b1;
        rd          = rd_i;
        ld_size     = sz;
        ld_unsigned = uns;
        step();
        in_valid   = 1'b0;
        alu_result = 32'hDEAD_BEEF;
        for (int unsigned i = 1; i <= nwait; i++) begin
            if (i == nwait) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end else begin
                mem_rdata = ~rdata;
            end
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_noerr"}, 32'(err_timeout), 32'd0);
            check({tag, "_rdy"}, 32'(in_ready), 32'd0);
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        @(negedge clk);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        alu_result  = '0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        rd          = '0;
        ld_size     = '0;
        ld_unsigned = 1'b0;
        mem_rdata   = '0;
        mem_rvalid  = 1'b0;

        // Reset values
        #2;
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Single ALU op, latency 1
        alu_op(5'd3, 32'h1234_5678);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("alu_we", 32'(rf_we), 32'd1);
        check("alu_waddr", 32'(rf_waddr), 32'd3);
        check("alu_wdata", rf_wdata, 32'h1234_5678);
        step();
        @(negedge clk);
        check("alu_we_drop", 32'(rf_we), 32'd0);
        check("alu_waddr_hold", 32'(rf_waddr), 32'd3);
        check("alu_wdata_hold", rf_wdata, 32'h1234_5678);
        step();

        // Back-to-back ALU ops
        alu_op(5'd1, 32'h0000_0011);
        step();
        alu_op(5'd2, 32'h0000_0022);
        @(negedge clk);
        check("b2b1_we", 32'(rf_we), 32'd1);
        check("b2b1_waddr", 32'(rf_waddr), 32'd1);
        check("b2b1_rdy", 32'(in_ready), 32'd1);
        step();
        alu_op(5'd3, 32'h0000_0033);
        @(negedge clk);
        check("b2b2_we", 32'(rf_we), 32'd1);
        check("b2b2_waddr", 32'(rf_waddr), 32'd2);
        check("b2b2_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b3_we", 32'(rf_we), 32'd1);
        check("b2b3_waddr", 32'(rf_waddr), 32'd3);
        check("b2b3_wdata", rf_wdata, 32'h0000_0033);
        step();

        // Signed byte load, offset 2, four wait cycles
        do_load("ldsb", 5'd5, 32'h0000_0102, 2'b00, 1'b0, 32'h0080_0000, 4);
        check("ldsb_we", 32'(rf_we), 32'd1);
        check("ldsb_waddr", 32'(rf_waddr), 32'd5);
        check("ldsb_wdata", rf_wdata, 32'hFFFF_FF80);
        step();

        // Same, unsigned
        do_load("ldub", 5'd6, 32'h0000_0102, 2'b00, 1'b1, 32'h0080_0000, 4);
        check("ldub_wdata", rf_wdata, 32'h0000_0080);
        step();

        // Signed half load, offset 3 (bit 0 ignored)
        do_load("ldsh", 5'd7, 32'h0000_0203, 2'b01, 1'b0, 32'h8001_7FFF, 2);
        check("ldsh_wdata", rf_wdata, 32'hFFFF_8001);
        step();

        // Unsigned half, lower half
        do_load("lduh", 5'd7, 32'h0000_0200, 2'b01, 1'b1, 32'h8001_F00F, 1);
        check("lduh_wdata", rf_wdata, 32'h0000_F00F);
        step();

        // Unsigned byte offset 3, signed byte offset 0
        do_load("ldub3", 5'd8, 32'h0000_0007, 2'b00, 1'b1, 32'hA500_0000, 1);
        check("ldub3_wdata", rf_wdata, 32'h0000_00A5);
        step();
        do_load("ldsb0", 5'd8, 32'h0000_0004, 2'b00, 1'b0, 32'h1234_567F, 1);
        check("ldsb0_wdata", rf_wdata, 32'h0000_007F);
        step();

        // Word load, offset ignored; rvalid on the 8th wait cycle beats timeout
        do_load("ldw", 5'd9, 32'h0000_0011, 2'b10, 1'b0, 32'h89AB_CDEF, 8);
        check("ldw_we", 32'(rf_we), 32'd1);
        check("ldw_waddr", 32'(rf_waddr), 32'd9);
        check("ldw_wdata", rf_wdata, 32'h89AB_CDEF);
        step();

        // Timeout: no rvalid, err_timeout on the 8th wait cycle
        in_valid   = 1'b1;
        alu_result = 32'h0000_0100;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        rd         = 5'd10;
        ld_size    = 2'b10;
        step();
        in_valid = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("to_busy", 32'(busy), 32'd1);
            check("to_err", 32'(err_timeout), (i == 8) ? 32'd1 : 32'd0);
            check("to_we", 32'(rf_we), 32'd0);
            step();
        end
        @(negedge clk);
        check("to_rdy_after", 32'(in_ready), 32'd1);
        check("to_err_after", 32'(err_timeout), 32'd0);
        check("to_busy_after", 32'(busy), 32'd0);
        check("to_we_after", 32'(rf_we), 32'd0);
        check("to_waddr_hold", 32'(rf_waddr), 32'd9);
        step();

        // rd=0 load: discarded
        do_load("ldr0", 5'd0, 32'h0000_0000, 2'b10, 1'b0, 32'hCAFE_F00D, 2);
        check("ldr0_we", 32'(rf_we), 32'd0);
        check("ldr0_wdata_hold", rf_wdata, 32'h89AB_CDEF);
        step();

        // Reset during WAIT_MEM, then a stray rvalid
        in_valid   = 1'b1;
        alu_result = 32'h0000_0000;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        rd         = 5'd12;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_we", 32'(rf_we), 32'd0);
        check("mid_rst_waddr", 32'(rf_waddr), 32'd0);
        check("mid_rst_wdata", rf_wdata, 32'd0);
        check("mid_rst_err", 32'(err_timeout), 32'd0);
        step();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("stray_we", 32'(rf_we), 32'd0);
        check("stray_wdata", rf_wdata, 32'd0);
        check("stray_busy", 32'(busy), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
